mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
- Multicycle main controller for the MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback over a shared memory/ALU, one instruction at a time.
- Drives every datapath select/enable, including the immediate-extension mode (sign vs zero) consumed by the 16→32 extender.
- Sits between the IR (op/funct) and the datapath muxes; memory handshake via mem_ready.

Parameters:
- ST_W, 4, state register width (12 states used)

Ports:
- clk  in  1  clock, all state changes on rising edge
- rst_n  in  1  synchronous reset, active-low
- op  in  6  IR[31:26]
- funct  in  6  IR[5:0] (informational; ALU decoder consumes it)
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- pc_en  out  1  PC load enable (unconditional or taken branch)
- iord  out  1  0=PC addresses memory, 1=ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR load enable
- reg_dst  out  1  0=rt, 1=rd
- mem_to_reg  out  1  0=ALUOut, 1=MDR
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0=PC, 1=A
- alu_src_b  out  2  00=B, 01=4, 10=ext imm, 11=ext imm<<2
- alu_op  out  2  00=add, 01=sub, 10=by funct, 11=by opcode
- pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target
- ext_op  out  1  1=sign-extend, 0=zero-extend
- illegal  out  1  one-cycle pulse on unsupported opcode
- state  out  ST_W  current state (debug)

Behaviour:
- States (encoding): FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REXE=6, RWB=7, BR=8, JMP=9, IEXE=10, IWB=11.
- Reset: rst_n=0 at a rising edge forces state=FETCH. Mid-instruction reset aborts; no writeback occurs.
- Outputs are a decode of state (plus mem_ready/zero/op where noted). In FETCH every strobe is 0 except mem_read=1. illegal=0.
- FETCH:
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write=pc_en=mem_ready. Stay while mem_ready=0; on mem_ready=1 → DECODE.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute).
  - Next state by op: 000000→REXE; 100011/101011→MEMADR; 000100/000101→BR; 000010→JMP; 001000/001010/001100/001101→IEXE.
  - Any other op → FETCH with illegal=1 for this cycle only.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. lw → MEMRD, sw → MEMWR.
- MEMRD: mem_read=1, iord=1. Wait for mem_ready; then → MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1 → FETCH.
- MEMWR: mem_write=1, iord=1. Hold until mem_ready; then → FETCH.
- REXE: alu_src_a=1, alu_src_b=00, alu_op=10 → RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0 → FETCH.
- BR: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01. pc_en = zero for beq, ~zero for bne → FETCH.
- JMP: pc_src=10, pc_en=1 → FETCH.
- IEXE: alu_src_a=1, alu_src_b=10, alu_op=11 → IWB.
- IWB: reg_write=1, reg_dst=0, mem_to_reg=0 → FETCH.
- ext_op: 0 when op ∈ {001100 andi, 001101 ori}; 1 otherwise, in all states.
- Zero-wait latency (cycles incl. FETCH): lw 5, sw 4, R 4, I-type 4, beq/bne 3, j 3. Each wait cycle on mem_ready adds 1.
- mem_write and reg_write never both 1. pc_en is never asserted outside FETCH/BR/JMP.

Test Plan:
- Reset: rst_n=0 for 2 cycles mid-REXE → state=0, reg_write=0, mem_write=0. Release → mem_read=1, iord=0.
- lw (op=100011), mem_ready held 1 → states 0,1,2,3,4,0. reg_write=1 only in state 4, with mem_to_reg=1. ext_op=1 throughout.
- sw with mem_ready=0 for 3 cycles in MEMWR → mem_write=1 for 4 cycles, then state=0. reg_write never 1.
- beq with zero=1 → pc_en=1, pc_src=01 in BR. bne with zero=1 → pc_en=0 in BR. Both return to FETCH after 3 cycles.
- ori (op=001101) → ext_op=0, alu_src_b=10, alu_op=11 in IEXE. Then IWB: reg_write=1, reg_dst=0. addi (001000) → ext_op=1.
- op=111111 → illegal=1 for exactly the DECODE cycle, next state=0, no writes; then a j (000010) completes with pc_src=10, pc_en=1.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS main controller: walks each instruction through fetch/decode/execute/
// memory/writeback and drives every datapath select, strobe and the immediate-extension mode.
module mc_ctrl_fsm #(
    parameter int ST_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [5:0]      op,
    input  logic [5:0]      funct,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            pc_en,
    output logic            iord,
    output logic            mem_read,
    output logic            mem_write,
    output logic            ir_write,
    output logic            reg_dst,
    output logic            mem_to_reg,
    output logic            reg_write,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      alu_op,
    output logic [1:0]      pc_src,
    output logic            ext_op,
    output logic            illegal,
    output logic [ST_W-1:0] state
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    typedef enum logic [ST_W-1:0] {
        FETCH  = ST_W'(0),
        DECODE = ST_W'(1),
        MEMADR = ST_W'(2),
        MEMRD  = ST_W'(3),
        MEMWB  = ST_W'(4),
        MEMWR  = ST_W'(5),
        REXE   = ST_W'(6),
        RWB    = ST_W'(7),
        BR     = ST_W'(8),
        JMP    = ST_W'(9),
        IEXE   = ST_W'(10),
        IWB    = ST_W'(11)
    } state_t;

    state_t state_q;
    state_t state_d;

    // funct is decoded by the separate ALU decoder, not here.
    logic unused_funct;
    assign unused_funct = ^funct;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        illegal    = 1'b0;

        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
                if (mem_ready) begin
                    state_d = DECODE;
                end
            end
            // The ALU is otherwise idle here, so it precomputes the branch target.
            DECODE: begin
                alu_src_b = 2'b11;
                case (op)
                    OP_RTYPE:                          state_d = REXE;
                    OP_LW, OP_SW:                      state_d = MEMADR;
                    OP_BEQ, OP_BNE:                    state_d = BR;
                    OP_J:                              state_d = JMP;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = IEXE;
                    default: begin
                        state_d = FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) begin
                    state_d = MEMWB;
                end
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = FETCH;
            end
            MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    state_d = FETCH;
                end
            end
            REXE: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = RWB;
            end
            RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = FETCH;
            end
            BR: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                pc_en     = (op == OP_BEQ) ? zero : ~zero;
                state_d   = FETCH;
            end
            JMP: begin
                pc_src  = 2'b10;
                pc_en   = 1'b1;
                state_d = FETCH;
            end
            IEXE: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b11;
                state_d   = IWB;
            end
            IWB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // Logical immediates are zero-extended; everything else sign-extends.
    assign ext_op = !((op == OP_ANDI) || (op == OP_ORI));
    assign state  = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: directed scenarios plus randomized instruction streams
// checked cycle by cycle against a per-instruction state-sequence model and output table.
module tb_mc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       alu_src_a, ext_op, illegal;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [3:0] state;

    int total = 0;
    int bad   = 0;

    logic [16:0] obs;
    logic [16:0] rows [12];

    mc_ctrl_fsm #(.ST_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
        .ext_op(ext_op), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    assign obs = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                  alu_src_a, alu_src_b, alu_op, pc_src, ext_op, illegal};

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h expected=%0h state=%0d op=%b t=%0t", tag, got, exp, state, op, $time);
        end
    endtask

    function automatic logic [16:0] mk(input bit pe, input bit io, input bit mr, input bit mw,
                                       input bit irw, input bit rd, input bit m2r, input bit rw,
                                       input bit sa, input bit [1:0] sb, input bit [1:0] ao,
                                       input bit [1:0] ps);
        return {pe, io, mr, mw, irw, rd, m2r, rw, sa, sb, ao, ps, 2'b00};
    endfunction

    function automatic bit isLegal(input logic [5:0] o);
        return o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                         6'b000010, 6'b001000, 6'b001010, 6'b001100, 6'b001101};
    endfunction

    // Static per-state row, then the fields that depend on mem_ready, zero or op.
    function automatic logic [16:0] expected(input int s, input logic [5:0] o, input logic z, input logic r);
        logic [16:0] v;
        if (s < 0 || s > 11) return '1;
        v = rows[s];
        if (s == 0) begin
            v[16] = r;
            v[12] = r;
        end
        if (s == 1) v[0] = !isLegal(o);
        if (s == 8) v[16] = (o == 6'b000100) ? z : !z;
        v[1] = !(o == 6'b001100 || o == 6'b001101);
        return v;
    endfunction

    // Runs one instruction from FETCH back to FETCH. waits<0 randomizes mem_ready; otherwise
    // FETCH is ready at once and each memory state stalls exactly 'waits' cycles.
    task automatic applyStimulus(input logic [5:0] o, input logic z, input int waits,
                                 output int mw_n, output int rw_n, output int ill_n);
        int seq[$];
        int idx;
        int cyc;
        int hold;
        int s;
        case (o)
            6'b000000:                                  seq = '{0, 1, 6, 7};
            6'b100011:                                  seq = '{0, 1, 2, 3, 4};
            6'b101011:                                  seq = '{0, 1, 2, 5};
            6'b000100, 6'b000101:                       seq = '{0, 1, 8};
            6'b000010:                                  seq = '{0, 1, 9};
            6'b001000, 6'b001010, 6'b001100, 6'b001101: seq = '{0, 1, 10, 11};
            default:                                    seq = '{0, 1};
        endcase
        idx = 0; cyc = 0; hold = 0;
        mw_n = 0; rw_n = 0; ill_n = 0;
        while (idx < seq.size()) begin
            s = seq[idx];
            @(negedge clk);
            op    = o;
            zero  = z;
            funct = 6'($urandom);
            if ((s == 3 || s == 5) && waits >= 0) mem_ready = (hold >= waits);
            else if (s == 0 && waits >= 0)       mem_ready = 1'b1;
            else                                 mem_ready = ($urandom_range(0, 99) < 70);
            #1;
            checkOutput("state", 32'(state), 32'(s));
            checkOutput("outputs", 32'(obs), 32'(expected(s, o, z, mem_ready)));
            mw_n += int'(mem_write);
            rw_n += int'(reg_write);
            ill_n += int'(illegal);
            if ((s == 0 || s == 3 || s == 5) && !mem_ready) begin
                hold++;
            end else begin
                idx++;
                hold = 0;
            end
            cyc++;
            if (cyc > 400) begin
                checkOutput("instr_timeout", 32'(cyc), 32'd0);
                break;
            end
        end
    endtask

    // Counts cycles from FETCH until the DUT itself is back in FETCH, memory always ready.
    task automatic measureLatency(input logic [5:0] o, input logic z, output int n);
        @(negedge clk);
        op = o;
        zero = z;
        mem_ready = 1'b1;
        n = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            if (state == 4'd0) break;
            n++;
        end
        mem_ready = 1'b0;
    endtask

    initial begin
        int mw, rw, il, lat;
        logic [5:0] pool [10];
        logic [5:0] o;
        int pick;

        pool = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                 6'b000010, 6'b001000, 6'b001010, 6'b001100, 6'b001101};
        rows[0]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 2'd0);
        rows[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd3, 2'd0, 2'd0);
        rows[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd0, 2'd0);
        rows[3]  = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0);
        rows[4]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 2'd0, 2'd0, 2'd0);
        rows[5]  = mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0);
        rows[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd2, 2'd0);
        rows[7]  = mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 2'd0, 2'd0, 2'd0);
        rows[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd1, 2'd1);
        rows[9]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd2);
        rows[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd3, 2'd0);
        rows[11] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0);

        rst_n = 1'b0; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("rst_state", 32'(state), 32'd0);
        checkOutput("rst_mem_read", 32'(mem_read), 32'd1);
        rst_n = 1'b1;

        // Abort an R-type in REXE with a two-cycle reset.
        @(negedge clk); op = 6'b000000; mem_ready = 1'b1;
        @(negedge clk); mem_ready = 1'b0;
        @(negedge clk); #1;
        checkOutput("pre_rst_rexe", 32'(state), 32'd6);
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk); #1;
            checkOutput("mid_rst_state", 32'(state), 32'd0);
            checkOutput("mid_rst_reg_write", 32'(reg_write), 32'd0);
            checkOutput("mid_rst_mem_write", 32'(mem_write), 32'd0);
        end
        rst_n = 1'b1;
        mem_ready = 1'b0;
        #1;
        checkOutput("post_rst_mem_read", 32'(mem_read), 32'd1);
        checkOutput("post_rst_iord", 32'(iord), 32'd0);

        applyStimulus(6'b100011, 1'b0, 0, mw, rw, il);
        checkOutput("lw_reg_write_cycles", 32'(rw), 32'd1);
        checkOutput("lw_mem_write_cycles", 32'(mw), 32'd0);

        applyStimulus(6'b101011, 1'b0, 3, mw, rw, il);
        checkOutput("sw_mem_write_cycles", 32'(mw), 32'd4);
        checkOutput("sw_reg_write_cycles", 32'(rw), 32'd0);

        applyStimulus(6'b000100, 1'b1, 0, mw, rw, il);
        applyStimulus(6'b000101, 1'b1, 0, mw, rw, il);
        applyStimulus(6'b001101, 1'b0, 0, mw, rw, il);
        checkOutput("ori_reg_write_cycles", 32'(rw), 32'd1);
        applyStimulus(6'b001000, 1'b0, 0, mw, rw, il);

        applyStimulus(6'b111111, 1'b0, 0, mw, rw, il);
        checkOutput("illegal_pulses", 32'(il), 32'd1);
        checkOutput("illegal_writes", 32'(mw + rw), 32'd0);
        applyStimulus(6'b000010, 1'b0, 0, mw, rw, il);
        checkOutput("j_illegal", 32'(il), 32'd0);

        measureLatency(6'b100011, 1'b0, lat); checkOutput("lat_lw", 32'(lat), 32'd5);
        measureLatency(6'b101011, 1'b0, lat); checkOutput("lat_sw", 32'(lat), 32'd4);
        measureLatency(6'b000000, 1'b0, lat); checkOutput("lat_r", 32'(lat), 32'd4);
        measureLatency(6'b001010, 1'b0, lat); checkOutput("lat_i", 32'(lat), 32'd4);
        measureLatency(6'b000100, 1'b1, lat); checkOutput("lat_beq", 32'(lat), 32'd3);
        measureLatency(6'b000101, 1'b0, lat); checkOutput("lat_bne", 32'(lat), 32'd3);
        measureLatency(6'b000010, 1'b0, lat); checkOutput("lat_j", 32'(lat), 32'd3);

        for (int i = 0; i < 300; i++) begin
            pick = $urandom_range(0, 10);
            if (pick == 10) o = 6'($urandom);
            else            o = pool[pick];
            applyStimulus(o, 1'($urandom), -1, mw, rw, il);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
